// File: rtl/winddir_pkg.sv
//------------------------------------------------------------------------------
// Module : winddir_pkg
// Brief  : Shared types and defaults for the ultrasonic anemometer tx path.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package winddir_pkg;

    localparam int NTX = 4;

    localparam int c_CLK_DIV_DEF = 625;   // 40 kHz tone from a 50 MHz clock
    localparam int c_BLANK_DEF   = 200;
    localparam int c_RXWIN_DEF   = 4096;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BURST  = 3'd1,
        ST_BLANK  = 3'd2,
        ST_LISTEN = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic [NTX-1:0] tx_onehot(input logic [1:0] sel);
        tx_onehot = NTX'(1) << sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/us_tone_gen.sv
//------------------------------------------------------------------------------
// Module : us_tone_gen
// Brief  : Enable-gated square-wave divider; level starts high on each enable.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module us_tone_gen #(
    parameter int CLK_DIV = 625
) (
    input  logic clock,
    input  logic reset,
    input  logic i_en,
    output logic o_level,
    output logic o_strobe
);

    localparam int c_CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_DIV - 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_level;

    // Held at count 0 / level high while disabled so a burst always starts high.
    always_ff @(posedge clock) begin
        if (!reset || !i_en) begin
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else if (r_cnt == c_LAST) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_level  = r_level;
    assign o_strobe = i_en && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/us_burst_tx.sv
//------------------------------------------------------------------------------
// Module : us_burst_tx
// Brief  : Fires four transducers in turn, blanks ringdown, opens rx windows.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module us_burst_tx
    import winddir_pkg::*;
#(
    parameter int CLK_DIV = c_CLK_DIV_DEF,
    parameter int BLANK   = c_BLANK_DEF,
    parameter int RXWIN   = c_RXWIN_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] npulse,
    output logic [3:0] tx,
    output logic [1:0] txsel,
    output logic       endata,
    output logic       busy,
    output logic       done
);

    localparam int c_WMAX = (BLANK > RXWIN) ? BLANK : RXWIN;
    localparam int c_WW   = (c_WMAX > 1) ? $clog2(c_WMAX) : 1;
    localparam logic [c_WW-1:0] c_BLANK_LAST = c_WW'(BLANK - 1);
    localparam logic [c_WW-1:0] c_RXWIN_LAST = c_WW'(RXWIN - 1);
    localparam logic [1:0]      c_SEL_LAST   = 2'(NTX - 1);

    state_t           r_state, w_state_nx;
    logic [1:0]       r_txsel, w_txsel_nx;
    logic [3:0]       r_npl, w_npl_nx;
    logic [4:0]       r_hcnt, w_hcnt_nx;
    logic [c_WW-1:0]  r_wcnt, w_wcnt_nx;
    logic [NTX-1:0]   r_tx, w_tx_nx;
    logic             r_endata, r_busy, r_done;
    logic             w_level, w_strobe, w_level_nx;
    logic [4:0]       w_hlast;

    us_tone_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tone (
        .clock    (clock),
        .reset    (reset),
        .i_en     (r_state == ST_BURST),
        .o_level  (w_level),
        .o_strobe (w_strobe)
    );

    // Last half-period index of a burst: 2*npl-1.
    assign w_hlast = {r_npl, 1'b0} - 5'd1;

    always_comb begin
        w_state_nx = r_state;
        w_txsel_nx = r_txsel;
        w_npl_nx   = r_npl;
        w_hcnt_nx  = r_hcnt;
        w_wcnt_nx  = r_wcnt;

        case (r_state)
            ST_IDLE: begin
                w_txsel_nx = 2'd0;
                if (start) begin
                    w_npl_nx   = (npulse == 4'd0) ? 4'd1 : npulse;
                    w_hcnt_nx  = '0;
                    w_wcnt_nx  = '0;
                    w_state_nx = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_strobe) begin
                    if (r_hcnt == w_hlast) begin
                        w_hcnt_nx  = '0;
                        w_state_nx = ST_BLANK;
                    end else begin
                        w_hcnt_nx = r_hcnt + 5'd1;
                    end
                end
            end
            ST_BLANK: begin
                if (r_wcnt == c_BLANK_LAST) begin
                    w_wcnt_nx  = '0;
                    w_state_nx = ST_LISTEN;
                end else begin
                    w_wcnt_nx = r_wcnt + 1'b1;
                end
            end
            ST_LISTEN: begin
                if (r_wcnt == c_RXWIN_LAST) begin
                    w_wcnt_nx = '0;
                    if (r_txsel == c_SEL_LAST) begin
                        w_state_nx = ST_DONE;
                    end else begin
                        w_txsel_nx = r_txsel + 2'd1;
                        w_state_nx = ST_BURST;
                    end
                end else begin
                    w_wcnt_nx = r_wcnt + 1'b1;
                end
            end
            ST_DONE: begin
                w_txsel_nx = 2'd0;
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_txsel_nx = 2'd0;
                w_state_nx = ST_IDLE;
            end
        endcase

        if (abort && (r_state != ST_IDLE)) begin
            w_state_nx = ST_IDLE;
            w_txsel_nx = 2'd0;
            w_hcnt_nx  = '0;
            w_wcnt_nx  = '0;
        end
    end

    // Outputs are registered from next-state values, so the tone level for the
    // coming cycle is predicted here rather than taken from the divider as-is.
    always_comb begin
        w_level_nx = 1'b1;
        if (r_state == ST_BURST && w_state_nx == ST_BURST)
            w_level_nx = w_strobe ? ~w_level : w_level;
        w_tx_nx = '0;
        if (w_state_nx == ST_BURST && w_level_nx)
            w_tx_nx = tx_onehot(w_txsel_nx);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_txsel  <= 2'd0;
            r_npl    <= 4'd0;
            r_hcnt   <= '0;
            r_wcnt   <= '0;
            r_tx     <= '0;
            r_endata <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_txsel  <= w_txsel_nx;
            r_npl    <= w_npl_nx;
            r_hcnt   <= w_hcnt_nx;
            r_wcnt   <= w_wcnt_nx;
            r_tx     <= w_tx_nx;
            r_endata <= (w_state_nx == ST_LISTEN);
            r_busy   <= (w_state_nx != ST_IDLE);
            r_done   <= (w_state_nx == ST_DONE);
        end
    end

    assign tx     = r_tx;
    assign txsel  = r_txsel;
    assign endata = r_endata;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_us_burst_tx.sv
//------------------------------------------------------------------------------
// Module : tb_us_burst_tx
// Brief  : Directed self-checking bench for us_burst_tx (CLK_DIV=4, BLANK=10, RXWIN=20).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_us_burst_tx;

    localparam int c_DIV = 4;
    localparam int c_BLK = 10;
    localparam int c_RXW = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] npulse = 4'd0;
    logic [3:0] tx;
    logic [1:0] txsel;
    logic       endata, busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    us_burst_tx #(
        .CLK_DIV (c_DIV),
        .BLANK   (c_BLK),
        .RXWIN   (c_RXW)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .npulse (npulse),
        .tx     (tx),
        .txsel  (txsel),
        .endata (endata),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packed view {tx, endata, txsel, busy, done}
    function automatic logic [8:0] obs();
        return {tx, endata, txsel, busy, done};
    endfunction

    // Starts a cycle with npulse=np and checks every cycle until back in IDLE.
    // At cycle poke_k, start is pulsed and npulse moved to 5 (must be ignored).
    task automatic run_check(input int np, input int poke_k, input bit abort_too);
        int npl, blen, per, total, o, f, ndone, done_at, overlap;
        logic [3:0] etx;
        logic       een;
        logic [8:0] exp;
        npl   = (np == 0) ? 1 : np;
        blen  = 2 * npl * c_DIV;
        per   = blen + c_BLK + c_RXW;
        total = 4 * per + 1;
        ndone = 0; done_at = -1; overlap = 0;
        npulse = 4'(np);
        start  = 1'b1;
        abort  = abort_too;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k <= total; k++) begin
            if (k < total - 1) begin
                f   = k / per;
                o   = k % per;
                etx = ((o < blen) && (((o / c_DIV) % 2) == 0)) ? (4'd1 << f) : 4'd0;
                een = (o >= blen + c_BLK);
                exp = {etx, een, 2'(f), 1'b1, 1'b0};
            end else if (k == total - 1) begin
                exp = {4'd0, 1'b0, 2'd3, 1'b1, 1'b1};
            end else begin
                exp = 9'd0;
            end
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
            if (endata && (tx != 4'd0)) overlap++;
            chk($sformatf("np%0d_k%0d", np, k), 32'(obs()), 32'(exp));
            start = 1'b0;
            if (k == poke_k) begin
                start  = 1'b1;
                npulse = 4'd5;
            end
            tick();
        end
        start = 1'b0;
        chk($sformatf("np%0d_done_count", np), 32'(ndone), 32'd1);
        chk($sformatf("np%0d_done_at", np), 32'(done_at), 32'(total - 1));
        chk($sformatf("np%0d_overlap", np), 32'(overlap), 32'd0);
    endtask

    initial begin
        int nd;
        // Reset state
        repeat (3) tick();
        chk("reset_outputs", 32'(obs()), 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_after_reset", 32'(obs()), 32'd0);

        // abort in IDLE does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 32'(obs()), 32'd0);

        // Nominal npulse=2: 185-cycle measurement, done at cycle 184
        run_check(2, -1, 1'b0);
        // npulse=0 behaves as 1: 153 cycles
        run_check(0, -1, 1'b0);

        // Abort while listening after transducer 2 (cycle 77 of a npulse=2 run)
        npulse = 4'd2;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (77) tick();
        chk("pre_abort_listen", 32'(obs()), 32'({4'd0, 1'b1, 2'd1, 1'b1, 1'b0}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("post_abort", 32'(obs()), 32'd0);
        nd = 0;
        for (int i = 0; i < 150; i++) begin
            if (done || busy) nd++;
            tick();
        end
        chk("no_done_after_abort", 32'(nd), 32'd0);
        // Fresh start after abort begins at transducer 1
        run_check(2, -1, 1'b0);

        // start while busy plus npulse change: ignored until next start
        run_check(2, 30, 1'b0);
        // start and abort together in IDLE: start wins; npulse=5 takes effect
        run_check(5, -1, 1'b1);

        // Synchronous reset in BURST
        npulse = 4'd3;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        chk("reset_mid_burst", 32'(obs()), 32'd0);
        start = 1'b1;
        tick();
        chk("reset_blocks_start", 32'(obs()), 32'd0);
        start = 1'b0;
        reset = 1'b1;
        tick();
        chk("idle_after_release", 32'(obs()), 32'd0);
        run_check(2, -1, 1'b0);

        // Longest burst: 120 cycles, last half-period low
        run_check(15, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
